fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined CPU. It owns the program counter, drives the word address into the combinational instruction ROM, and registers the returned instruction into the IF/ID pipeline register for the decode stage. It applies stalls from the hazard unit, flushes and PC redirects from branch/jump resolution, and halts cleanly when the PC runs past the populated ROM.

## Interface
- ADDR_W, 4, ROM word-address width; ROM depth is 2^ADDR_W words.
- ROM_WORDS, 16, number of valid ROM words. Must satisfy ROM_WORDS ≤ 2^ADDR_W.
- RESET_PC, 32'h0000_0000, byte PC loaded at reset. Must be word-aligned.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  reset. Synchronous and active-low: one clock, and reset is sampled only on the rising edge of clk.
- stall_i  in  1  hazard unit: hold the PC and the IF/ID register.
- flush_i  in  1  load a bubble into IF/ID on the next edge.
- redirect_valid_i  in  1  branch/jump taken; load the PC from redirect_pc_i.
- redirect_pc_i  in  32  redirect target as a byte address.
- rom_addr_o  out  ADDR_W  ROM word address; equals pc[ADDR_W+1:2].
- rom_data_i  in  32  ROM instruction word. Combinational return for rom_addr_o.
- pc_o  out  32  current PC register.
- ifid_valid_o  out  1  IF/ID holds a real instruction.
- ifid_inst_o  out  32  registered instruction; 0 (NOP) when not valid.
- ifid_pc_o  out  32  PC of ifid_inst_o.
- ifid_pc4_o  out  32  ifid_pc_o + 4.
- halted_o  out  1  the PC is out of range and fetch is suspended.
- fault_o  out  1  sticky flag: a misaligned redirect was received.
- fetch_count_o  out  32  count of valid instructions loaded into IF/ID.

## Operation
- in_range = (pc < ROM_WORDS*4), using an unsigned 32-bit compare. halted_o = !in_range. halted_o is combinational from the PC register.
- PC next-state priority, highest first:
  1. Reset: pc ← RESET_PC.
  2. Redirect: pc ← {redirect_pc_i[31:2], 2'b00}. This takes effect even when stall_i or halted_o is asserted. If redirect_pc_i[1:0] ≠ 0, fault_o ← 1.
  3. stall_i: pc holds.
  4. halted_o: pc holds.
  5. Otherwise: pc ← pc + 4. The adder wraps modulo 2^32.
- IF/ID next-state priority, highest first:
  1. Reset: valid ← 0, inst ← 0, pc ← 0, pc4 ← 0.
  2. flush_i or redirect_valid_i: bubble (valid ← 0, inst ← 0). ifid pc/pc4 hold.
  3. stall_i: all IF/ID fields hold.
  4. halted_o: bubble.
  5. Otherwise: valid ← 1, inst ← rom_data_i, pc ← pc, pc4 ← pc + 4.
- fetch_count_o increments by 1 on exactly the edges where IF/ID case 5 applies. It wraps modulo 2^32.
- fault_o is sticky and is cleared only by reset.
- There is no branch delay slot. A redirect squashes the instruction currently being fetched.
- rom_addr_o is driven from the PC register only, never from next-PC. The ROM is purely combinational.

## Timing
- Reset values: pc_o = RESET_PC, ifid_valid_o = 0, ifid_inst_o = 0, ifid_pc_o = 0, ifid_pc4_o = 0, fault_o = 0, fetch_count_o = 0. halted_o follows RESET_PC.
- Fetch latency is 1 cycle: the word at PC p appears on ifid_inst_o in the cycle after pc_o = p.
- Steady state: one instruction per cycle.
- Redirect latency: with redirect_valid_i high at edge N, pc_o = target after N. IF/ID is a bubble after N. The target instruction is valid in IF/ID after N+1.
- stall_i together with flush_i: the PC holds and IF/ID becomes a bubble. This is the load-use bubble insertion case.
- Reset asserted mid-run: everything returns to reset values at the next edge, regardless of stall, flush or redirect. The first valid IF/ID entry appears one edge after rst_n is released.
- Halt exit occurs only through a redirect to an in-range PC. Sequential fetch past ROM_WORDS never aliases into low ROM words.

## Test plan
- Reset then run with ROM word i = 32'h1000_0000 + i:
  - edge 1 after release → ifid_pc_o = 0, inst = 32'h1000_0000, valid = 1.
  - edge 3 → ifid_pc_o = 8, fetch_count_o = 3.
- Stall for 2 cycles while pc_o = 0x10:
  - pc_o stays 0x10 and IF/ID holds pc = 0x0C.
  - Next edge after stall drops → ifid_pc_o = 0x10. fetch_count_o does not advance during the stall.
- Redirect to 0x08 with flush at pc_o = 0x20:
  - next edge → pc_o = 0x08, ifid_valid_o = 0.
  - following edge → ifid_pc_o = 0x08, inst = 32'h1000_0002.
- Run to end with ROM_WORDS = 16:
  - after ifid_pc_o = 0x3C, pc_o = 0x40, halted_o = 1, and ifid_valid_o = 0 on all further edges.
  - fetch_count_o = 16 and stays constant.
  - Redirect to 0x04 → halted_o = 0 and fetch resumes.
- Misaligned redirect to 0x0A → pc_o = 0x08 and fault_o = 1. fault_o stays 1 after further redirects and clears only on reset.
- Redirect, stall and flush all asserted in the same cycle as rst_n = 0 → all outputs equal their reset values after that edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational ROM and
// registers the returned word into the IF/ID pipeline register.
module fetch_stage #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned ROM_WORDS = 16,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              redirect_valid_i,
  input  logic [31:0]       redirect_pc_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [31:0]       rom_data_i,
  output logic [31:0]       pc_o,
  output logic              ifid_valid_o,
  output logic [31:0]       ifid_inst_o,
  output logic [31:0]       ifid_pc_o,
  output logic [31:0]       ifid_pc4_o,
  output logic              halted_o,
  output logic              fault_o,
  output logic [31:0]       fetch_count_o
);

  // Byte limit of the populated ROM; 33 bits so ROM_WORDS*4 cannot overflow.
  localparam logic [32:0] ROM_LIMIT = 33'(ROM_WORDS) << 2;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        in_range;
  logic        load_ifid;

  assign pc_plus4   = pc + 32'd4;
  assign in_range   = ({1'b0, pc} < ROM_LIMIT);
  assign halted_o   = !in_range;
  assign rom_addr_o = pc[ADDR_W+1:2];
  assign pc_o       = pc;

  // A real instruction enters IF/ID only when nothing higher-priority intervenes.
  assign load_ifid = !flush_i && !redirect_valid_i && !stall_i && in_range;

  // PC register: redirect beats stall and halt; halt exits only via redirect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid_i) begin
      pc <= {redirect_pc_i[31:2], 2'b00};
    end else if (!stall_i && in_range) begin
      pc <= pc_plus4;
    end
  end

  // Sticky misaligned-redirect flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_o <= 1'b0;
    end else if (redirect_valid_i && (redirect_pc_i[1:0] != 2'b00)) begin
      fault_o <= 1'b1;
    end
  end

  // IF/ID register: bubbles keep the previous pc/pc4 so only valid/inst change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ifid_valid_o <= 1'b0;
      ifid_inst_o  <= '0;
      ifid_pc_o    <= '0;
      ifid_pc4_o   <= '0;
    end else if (flush_i || redirect_valid_i) begin
      ifid_valid_o <= 1'b0;
      ifid_inst_o  <= '0;
    end else if (stall_i) begin
      ifid_valid_o <= ifid_valid_o;
    end else if (!in_range) begin
      ifid_valid_o <= 1'b0;
      ifid_inst_o  <= '0;
    end else begin
      ifid_valid_o <= 1'b1;
      ifid_inst_o  <= rom_data_i;
      ifid_pc_o    <= pc;
      ifid_pc4_o   <= pc_plus4;
    end
  end

  // Count of real instructions loaded into IF/ID.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count_o <= '0;
    end else if (load_ifid) begin
      fetch_count_o <= fetch_count_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with ROM word i = 0x1000_0000 + i.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        flush_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic [3:0]  rom_addr_o;
  logic [31:0] rom_data_i;
  logic [31:0] pc_o;
  logic        ifid_valid_o;
  logic [31:0] ifid_inst_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_pc4_o;
  logic        halted_o;
  logic        fault_o;
  logic [31:0] fetch_count_o;

  int checks = 0;
  int errors = 0;

  fetch_stage #(
    .ADDR_W   (4),
    .ROM_WORDS(16),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i   (redirect_pc_i),
    .rom_addr_o      (rom_addr_o),
    .rom_data_i      (rom_data_i),
    .pc_o            (pc_o),
    .ifid_valid_o    (ifid_valid_o),
    .ifid_inst_o     (ifid_inst_o),
    .ifid_pc_o       (ifid_pc_o),
    .ifid_pc4_o      (ifid_pc4_o),
    .halted_o        (halted_o),
    .fault_o         (fault_o),
    .fetch_count_o   (fetch_count_o)
  );

  // Combinational ROM model
  assign rom_data_i = 32'h1000_0000 + 32'(rom_addr_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall_i = 1'b1; flush_i = 1'b1;
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h0000_0022;
    tick(); tick();
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp %h", pc_o, 32'h0); end
    checks++; if (ifid_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", ifid_valid_o); end
    checks++; if (ifid_inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h exp 0", ifid_inst_o); end
    checks++; if (ifid_pc_o !== 32'h0) begin errors++; $display("FAIL reset_ifid_pc: got %h exp 0", ifid_pc_o); end
    checks++; if (ifid_pc4_o !== 32'h0) begin errors++; $display("FAIL reset_ifid_pc4: got %h exp 0", ifid_pc4_o); end
    checks++; if (fault_o !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b exp 0", fault_o); end
    checks++; if (fetch_count_o !== 32'h0) begin errors++; $display("FAIL reset_count: got %h exp 0", fetch_count_o); end
    checks++; if (halted_o !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b exp 0", halted_o); end
  endtask

  task automatic test_run();
    rst_n = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    redirect_valid_i = 1'b0; redirect_pc_i = 32'h0;
    tick();
    checks++; if (ifid_pc_o !== 32'h0) begin errors++; $display("FAIL run1_ifid_pc: got %h exp 0", ifid_pc_o); end
    checks++; if (ifid_inst_o !== 32'h1000_0000) begin errors++; $display("FAIL run1_inst: got %h exp 10000000", ifid_inst_o); end
    checks++; if (ifid_valid_o !== 1'b1) begin errors++; $display("FAIL run1_valid: got %b exp 1", ifid_valid_o); end
    checks++; if (ifid_pc4_o !== 32'h4) begin errors++; $display("FAIL run1_pc4: got %h exp 4", ifid_pc4_o); end
    checks++; if (pc_o !== 32'h4) begin errors++; $display("FAIL run1_pc: got %h exp 4", pc_o); end
    tick(); tick();
    checks++; if (ifid_pc_o !== 32'h8) begin errors++; $display("FAIL run3_ifid_pc: got %h exp 8", ifid_pc_o); end
    checks++; if (fetch_count_o !== 32'd3) begin errors++; $display("FAIL run3_count: got %0d exp 3", fetch_count_o); end
    checks++; if (ifid_inst_o !== 32'h1000_0002) begin errors++; $display("FAIL run3_inst: got %h exp 10000002", ifid_inst_o); end
    checks++; if (rom_addr_o !== 4'h3) begin errors++; $display("FAIL run3_rom_addr: got %h exp 3", rom_addr_o); end
  endtask

  task automatic test_stall();
    tick(); // pc 0x10, ifid 0x0C, count 4
    stall_i = 1'b1;
    tick(); tick();
    checks++; if (pc_o !== 32'h10) begin errors++; $display("FAIL stall_pc: got %h exp 10", pc_o); end
    checks++; if (ifid_pc_o !== 32'hC) begin errors++; $display("FAIL stall_ifid_pc: got %h exp c", ifid_pc_o); end
    checks++; if (ifid_inst_o !== 32'h1000_0003) begin errors++; $display("FAIL stall_inst: got %h exp 10000003", ifid_inst_o); end
    checks++; if (fetch_count_o !== 32'd4) begin errors++; $display("FAIL stall_count: got %0d exp 4", fetch_count_o); end
    stall_i = 1'b0;
    tick();
    checks++; if (ifid_pc_o !== 32'h10) begin errors++; $display("FAIL unstall_ifid_pc: got %h exp 10", ifid_pc_o); end
    checks++; if (fetch_count_o !== 32'd5) begin errors++; $display("FAIL unstall_count: got %0d exp 5", fetch_count_o); end
  endtask

  task automatic test_redirect();
    tick(); tick(); tick(); // pc 0x20, count 8
    checks++; if (pc_o !== 32'h20) begin errors++; $display("FAIL pre_redir_pc: got %h exp 20", pc_o); end
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h8; flush_i = 1'b1;
    tick();
    redirect_valid_i = 1'b0; flush_i = 1'b0;
    checks++; if (pc_o !== 32'h8) begin errors++; $display("FAIL redir_pc: got %h exp 8", pc_o); end
    checks++; if (ifid_valid_o !== 1'b0) begin errors++; $display("FAIL redir_bubble: got %b exp 0", ifid_valid_o); end
    checks++; if (ifid_pc_o !== 32'h1C) begin errors++; $display("FAIL redir_pc_hold: got %h exp 1c", ifid_pc_o); end
    checks++; if (fetch_count_o !== 32'd8) begin errors++; $display("FAIL redir_count: got %0d exp 8", fetch_count_o); end
    tick();
    checks++; if (ifid_pc_o !== 32'h8) begin errors++; $display("FAIL redir_tgt_pc: got %h exp 8", ifid_pc_o); end
    checks++; if (ifid_inst_o !== 32'h1000_0002) begin errors++; $display("FAIL redir_tgt_inst: got %h exp 10000002", ifid_inst_o); end
    checks++; if (ifid_valid_o !== 1'b1) begin errors++; $display("FAIL redir_tgt_valid: got %b exp 1", ifid_valid_o); end
  endtask

  task automatic test_stall_flush();
    stall_i = 1'b1; flush_i = 1'b1;
    tick();
    stall_i = 1'b0; flush_i = 1'b0;
    checks++; if (pc_o !== 32'hC) begin errors++; $display("FAIL sf_pc: got %h exp c", pc_o); end
    checks++; if (ifid_valid_o !== 1'b0) begin errors++; $display("FAIL sf_bubble: got %b exp 0", ifid_valid_o); end
    checks++; if (ifid_inst_o !== 32'h0) begin errors++; $display("FAIL sf_inst: got %h exp 0", ifid_inst_o); end
    tick();
    checks++; if (ifid_pc_o !== 32'hC) begin errors++; $display("FAIL sf_resume_pc: got %h exp c", ifid_pc_o); end
    checks++; if (fetch_count_o !== 32'd10) begin errors++; $display("FAIL sf_count: got %0d exp 10", fetch_count_o); end
  endtask

  task automatic test_halt();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    checks++; if (ifid_pc_o !== 32'h3C) begin errors++; $display("FAIL end_ifid_pc: got %h exp 3c", ifid_pc_o); end
    checks++; if (pc_o !== 32'h40) begin errors++; $display("FAIL end_pc: got %h exp 40", pc_o); end
    checks++; if (halted_o !== 1'b1) begin errors++; $display("FAIL end_halted: got %b exp 1", halted_o); end
    checks++; if (fetch_count_o !== 32'd16) begin errors++; $display("FAIL end_count: got %0d exp 16", fetch_count_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ifid_valid_o !== 1'b0) begin errors++; $display("FAIL halt_valid[%0d]: got %b exp 0", i, ifid_valid_o); end
      checks++; if (pc_o !== 32'h40) begin errors++; $display("FAIL halt_pc[%0d]: got %h exp 40", i, pc_o); end
      checks++; if (fetch_count_o !== 32'd16) begin errors++; $display("FAIL halt_count[%0d]: got %0d exp 16", i, fetch_count_o); end
    end
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h4;
    tick();
    redirect_valid_i = 1'b0;
    checks++; if (halted_o !== 1'b0) begin errors++; $display("FAIL unhalt: got %b exp 0", halted_o); end
    tick();
    checks++; if (ifid_inst_o !== 32'h1000_0001) begin errors++; $display("FAIL unhalt_inst: got %h exp 10000001", ifid_inst_o); end
    checks++; if (fetch_count_o !== 32'd17) begin errors++; $display("FAIL unhalt_count: got %0d exp 17", fetch_count_o); end
  endtask

  task automatic test_fault();
    redirect_valid_i = 1'b1; redirect_pc_i = 32'hA;
    tick();
    checks++; if (pc_o !== 32'h8) begin errors++; $display("FAIL misalign_pc: got %h exp 8", pc_o); end
    checks++; if (fault_o !== 1'b1) begin errors++; $display("FAIL misalign_fault: got %b exp 1", fault_o); end
    stall_i = 1'b1; redirect_pc_i = 32'h10;
    tick();
    stall_i = 1'b0; redirect_valid_i = 1'b0;
    checks++; if (pc_o !== 32'h10) begin errors++; $display("FAIL redir_over_stall: got %h exp 10", pc_o); end
    checks++; if (fault_o !== 1'b1) begin errors++; $display("FAIL fault_sticky: got %b exp 1", fault_o); end
    tick();
    checks++; if (fault_o !== 1'b1) begin errors++; $display("FAIL fault_sticky2: got %b exp 1", fault_o); end
  endtask

  task automatic test_reset_midrun();
    rst_n = 1'b0; stall_i = 1'b1; flush_i = 1'b1;
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h2A;
    tick();
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL mid_pc: got %h exp 0", pc_o); end
    checks++; if (fault_o !== 1'b0) begin errors++; $display("FAIL mid_fault: got %b exp 0", fault_o); end
    checks++; if (fetch_count_o !== 32'h0) begin errors++; $display("FAIL mid_count: got %0d exp 0", fetch_count_o); end
    checks++; if (ifid_pc_o !== 32'h0) begin errors++; $display("FAIL mid_ifid_pc: got %h exp 0", ifid_pc_o); end
    checks++; if (ifid_pc4_o !== 32'h0) begin errors++; $display("FAIL mid_ifid_pc4: got %h exp 0", ifid_pc4_o); end
    checks++; if (ifid_valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b exp 0", ifid_valid_o); end
    rst_n = 1'b1; stall_i = 1'b0; flush_i = 1'b0; redirect_valid_i = 1'b0;
    tick();
    checks++; if (ifid_valid_o !== 1'b1) begin errors++; $display("FAIL mid_first_valid: got %b exp 1", ifid_valid_o); end
    checks++; if (fetch_count_o !== 32'd1) begin errors++; $display("FAIL mid_first_count: got %0d exp 1", fetch_count_o); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_stall();
    test_redirect();
    test_stall_flush();
    test_halt();
    test_fault();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
